// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encodings and sizing constants for the program loader.
package prog_loader_pkg;
  localparam int PROG_DEPTH_DEF     = 16;
  localparam int RELEASE_CYCLES_DEF = 2;
  localparam int ADDR_W             = 4;
  localparam int DATA_W             = 8;
  localparam int CNT_W              = 5;
  typedef logic [2:0] state_t;
  localparam state_t S_HOLD    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_VERIFY  = 3'd2;
  localparam state_t S_RELEASE = 3'd3;
  localparam state_t S_RUN     = 3'd4;
  localparam state_t S_ERROR   = 3'd5;
endpackage

// File: rtl/prog_loader_checksum.sv
// loader_checksum: modulo-256 byte accumulator with synchronous clear and enable.
module loader_checksum
  import prog_loader_pkg::*;
(
  input  logic              fastClk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);
  logic [DATA_W-1:0] sum_q;
  always_ff @(posedge fastClk or negedge rst) begin
    if (!rst) sum_q <= '0;
    else if (clr) sum_q <= '0;
    else if (en) sum_q <= sum_q + din;
  end
  assign sum = sum_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a checksummed program into RAM, verifies it by read-back,
// then releases the CPU from reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int PROG_DEPTH     = PROG_DEPTH_DEF,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic              fastClk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              run_start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              prog_mode,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              prog_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dp_q, dp_d;
  logic [DATA_W-1:0] lsum, rsum;
  logic              accept, wr, last, vdone, rel_done, enter_load, sum_clr, rsum_en;
  assign accept     = state_q == S_LOAD && byte_valid;
  assign wr         = accept && cnt_q < CNT_W'(PROG_DEPTH);
  assign last       = accept && cnt_q == CNT_W'(PROG_DEPTH);
  assign vdone      = state_q == S_VERIFY && cnt_q == CNT_W'(PROG_DEPTH + 1);
  assign rel_done   = state_q == S_RELEASE && cnt_q == CNT_W'(RELEASE_CYCLES - 1);
  assign enter_load = state_d == S_LOAD && state_q != S_LOAD;
  // Any entry into HOLD comes from an abort, which discards both sums.
  assign sum_clr    = enter_load || (state_d == S_HOLD && state_q != S_HOLD);
  // Read data lags the address by one cycle, so sum on counts 1..PROG_DEPTH.
  assign rsum_en    = state_q == S_VERIFY && cnt_q != '0 && cnt_q <= CNT_W'(PROG_DEPTH);
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:    state_d = load_start ? S_LOAD : run_start ? S_RELEASE : S_HOLD;
      S_LOAD:    state_d = abort ? S_HOLD : last ? (byte_data == lsum ? S_VERIFY : S_ERROR) : S_LOAD;
      S_VERIFY:  state_d = abort ? S_HOLD : vdone ? (rsum == lsum ? S_RELEASE : S_ERROR) : S_VERIFY;
      S_RELEASE: state_d = rel_done ? S_RUN : S_RELEASE;
      S_RUN:     state_d = load_start ? S_LOAD : S_RUN;
      S_ERROR:   state_d = load_start ? S_LOAD : S_ERROR;
      default:   state_d = S_HOLD;
    endcase
    cnt_d = state_d != state_q ? '0 :
            (state_q == S_VERIFY || state_q == S_RELEASE || wr) ? cnt_q + 1'b1 : cnt_q;
    dp_d  = enter_load ? 1'b0 : (state_q == S_VERIFY && state_d == S_RELEASE) ? 1'b1 : dp_q;
  end
  always_ff @(posedge fastClk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
    end
  end
  loader_checksum u_load_sum (
    .fastClk(fastClk), .rst(rst), .clr(sum_clr), .en(wr), .din(byte_data), .sum(lsum)
  );
  loader_checksum u_read_sum (
    .fastClk(fastClk), .rst(rst), .clr(sum_clr), .en(rsum_en), .din(ram_rdata), .sum(rsum)
  );
  assign byte_ready = state_q == S_LOAD;
  assign prog_we    = wr;
  assign prog_data  = wr ? byte_data : '0;
  assign prog_addr  = (wr || (state_q == S_VERIFY && cnt_q < CNT_W'(PROG_DEPTH))) ? cnt_q[ADDR_W-1:0] : '0;
  assign prog_mode  = !(state_q == S_RELEASE || state_q == S_RUN);
  assign cpu_rst_n  = state_q == S_RUN;
  assign busy       = state_q == S_LOAD || state_q == S_VERIFY;
  assign done       = state_q == S_RUN && dp_q;
  assign error      = state_q == S_ERROR;
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter PROG_DEPTH, default 16, number of RAM bytes loaded and verified.
REQ-002 Parameter RELEASE_CYCLES, default 2, cycles cpu_rst_n stays low after programming ends.
REQ-003 fastClk  input  1  single clock for the block; all state changes on its rising edge.
REQ-004 rst  input  1  reset is asynchronous and active-low.
REQ-005 load_start  input  1  one-cycle request to (re)program the RAM.
REQ-006 run_start  input  1  one-cycle request to release the CPU without loading.
REQ-007 abort  input  1  one-cycle request to cancel a load or verify.
REQ-008 byte_valid  input  1  byte_data holds a valid byte.
REQ-009 byte_data  input  8  incoming program or checksum byte.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 ram_rdata  input  8  RAM read data, valid one cycle after prog_addr is driven.
REQ-012 prog_mode  output  1  1 = RAM owned by loader and CPU stopped.
REQ-013 prog_addr  output  4  RAM address for a write or a read-back.
REQ-014 prog_data  output  8  RAM write data.
REQ-015 prog_we  output  1  RAM write strobe.
REQ-016 cpu_rst_n  output  1  active-low reset to the CPU datapath.
REQ-017 busy / done / error  output  1 each  LOAD or VERIFY active / RUN reached after a verified load / ERROR state.

Function
REQ-018 FSM states: HOLD, LOAD, VERIFY, RELEASE, RUN, ERROR.
REQ-019 HOLD: prog_mode=1 and cpu_rst_n=0; load_start goes to LOAD; run_start goes to RELEASE; if both are high, load_start wins.
REQ-020 LOAD: byte_ready=1; a byte is accepted only when byte_valid and byte_ready are both high; a byte with byte_valid=1 and byte_ready=0 is dropped.
REQ-021 Accepted bytes 0..PROG_DEPTH-1: same-cycle combinational write with prog_we=1, prog_addr=byte index and prog_data=byte_data; sum accumulates the byte modulo 256.
REQ-022 Accepted byte PROG_DEPTH is the checksum and is not written: it goes to VERIFY if it equals sum, otherwise to ERROR.
REQ-023 prog_we is 0 in every state and cycle other than those in REQ-021.
REQ-024 VERIFY: prog_addr steps 0..PROG_DEPTH-1, one address per cycle; ram_rdata is summed one cycle later; the read-back sum is checked in cycle PROG_DEPTH+1 after entry.
REQ-025 VERIFY exit: a match goes to RELEASE and sets done_pending; a mismatch goes to ERROR.
REQ-026 RELEASE: prog_mode=0 and cpu_rst_n=0 for exactly RELEASE_CYCLES cycles, then RUN.
REQ-027 RUN: prog_mode=0 and cpu_rst_n=1; done = done_pending; load_start goes to LOAD, with prog_mode=1 and cpu_rst_n=0 starting in the first LOAD cycle.
REQ-028 ERROR: error=1, prog_mode=1, cpu_rst_n=0; load_start goes to LOAD and clears error; run_start is ignored.
REQ-029 abort in LOAD or VERIFY goes to HOLD next cycle and discards the byte count and both sums; abort has no effect in other states.
REQ-030 An abort in the same cycle as a byte acceptance: the write (prog_we) still occurs and the transition to HOLD takes priority.
REQ-031 Entering LOAD clears the byte counter, sum, read-back sum and done_pending.
REQ-032 The byte counter is 5 bits wide and never wraps; bytes presented after the checksum byte are not accepted because the state has already left LOAD.
REQ-033 busy=1 in LOAD and VERIFY only.

Reset
REQ-034 While rst=0: state=HOLD, prog_mode=1, cpu_rst_n=0, byte_ready=0, prog_we=0, prog_addr=0, prog_data=0, busy=0, done=0, error=0, all counters and sums 0.
REQ-035 Reset asserted mid-LOAD or mid-VERIFY abandons the operation; the CPU stays held until an explicit load_start or run_start.

Structure
REQ-036 A shared package holds the state enum, PROG_DEPTH, RELEASE_CYCLES and the address/data width constants.
REQ-037 One sub-module, loader_checksum (8-bit modulo-256 accumulator with clear and enable), is instantiated twice: load sum and read-back sum.

Verification
REQ-038 Reset, load_start, bytes 0x01..0x10, checksum 0x88 -> 16 writes at addr 0..15; VERIFY passes with RAM model; RELEASE 2 cycles; RUN with done=1 and cpu_rst_n=1.
REQ-039 Same data with checksum 0x00 -> no write for the checksum byte, error=1, prog_mode=1; a following load_start clears error.
REQ-040 RAM model corrupts addr 5 (0x06 read as 0x07) -> read-back sum 0x89 differs from 0x88 -> ERROR.
REQ-041 abort after 7 bytes -> HOLD next cycle; a new load restarts writes at addr 0.
REQ-042 load_start and run_start together in HOLD -> LOAD; run_start alone -> RELEASE then RUN with done=0.
REQ-043 rst pulsed low mid-VERIFY -> every output at its REQ-034 value immediately, with no clock edge required.
